// File: rtl/spi_mem_ctrl_if.sv
// spi_mem_ctrl_if: SPI-frame and memory-side signals of the SPI memory controller
interface spi_mem_ctrl_if #(parameter int ADDR_SIZE = 8);
  logic [9:0]           rx_data;
  logic                 rx_valid;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [7:0]           mem_wdata;
  logic                 mem_we;
  logic                 mem_re;
  logic [7:0]           mem_rdata;
  logic                 busy;
  logic                 cmd_err;
  modport slave (
    input  rx_data, rx_valid, mem_rdata,
    output tx_data, tx_valid, mem_addr, mem_wdata, mem_we, mem_re, busy, cmd_err
  );
  modport master (
    output rx_data, rx_valid, mem_rdata,
    input  tx_data, tx_valid, mem_addr, mem_wdata, mem_we, mem_re, busy, cmd_err
  );
endinterface

// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: decodes SPI frames into single-cycle memory writes and 3-cycle read responses
module spi_mem_ctrl #(
  parameter int ADDR_SIZE = 8,
  parameter bit AUTO_INC  = 1'b0
) (
  input logic          clk,
  input logic          rst_n,
  spi_mem_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT, RESP} state_t;
  state_t               r_state, w_next;
  logic [ADDR_SIZE-1:0] r_wr_addr, r_rd_addr;
  logic                 r_wr_ok, r_rd_ok, r_cmd_err;
  logic [7:0]           r_wdata, r_tx_data;
  logic [1:0]           w_op;
  logic                 w_idle, w_wr, w_rd, w_err;
  assign w_op   = bus.rx_data[9:8];
  assign w_idle = r_state == IDLE;
  assign w_wr   = bus.rx_valid && w_idle && w_op == 2'b01 && r_wr_ok;
  assign w_rd   = bus.rx_valid && w_idle && w_op == 2'b11 && r_rd_ok;
  // frames arriving mid-operation are dropped and flagged, as are data ops without an address
  assign w_err  = bus.rx_valid && (!w_idle || (w_op == 2'b01 && !r_wr_ok) || (w_op == 2'b11 && !r_rd_ok));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = IDLE;
    w_next = w_idle ? (w_wr ? WRITE : w_rd ? RD_ISSUE : IDLE) :
             r_state == RD_ISSUE ? RD_WAIT :
             r_state == RD_WAIT ? RESP : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_addr <= '0;
      r_rd_addr <= '0;
      r_wr_ok   <= 1'b0;
      r_rd_ok   <= 1'b0;
      r_cmd_err <= 1'b0;
      r_wdata   <= '0;
      r_tx_data <= '0;
    end else begin
      r_cmd_err <= w_err;
      if (bus.rx_valid && w_idle && w_op == 2'b00) begin
        r_wr_addr <= bus.rx_data[ADDR_SIZE-1:0];
        r_wr_ok   <= 1'b1;
      end else if (AUTO_INC && r_state == WRITE) r_wr_addr <= r_wr_addr + ADDR_SIZE'(1);
      if (bus.rx_valid && w_idle && w_op == 2'b10) begin
        r_rd_addr <= bus.rx_data[ADDR_SIZE-1:0];
        r_rd_ok   <= 1'b1;
      end else if (AUTO_INC && r_state == RD_ISSUE) r_rd_addr <= r_rd_addr + ADDR_SIZE'(1);
      else if (!AUTO_INC && r_state == RESP) r_rd_ok <= 1'b0;
      if (w_wr) r_wdata <= bus.rx_data[7:0];
      if (r_state == RD_WAIT) r_tx_data <= bus.mem_rdata;
    end
  assign bus.mem_we    = r_state == WRITE;
  assign bus.mem_re    = r_state == RD_ISSUE;
  assign bus.mem_addr  = bus.mem_we ? r_wr_addr : bus.mem_re ? r_rd_addr : '0;
  assign bus.mem_wdata = bus.mem_we ? r_wdata : '0;
  assign bus.tx_data   = r_tx_data;
  assign bus.tx_valid  = r_state == RESP;
  assign bus.busy      = !w_idle;
  assign bus.cmd_err   = r_cmd_err;
endmodule

// File: tb/tb_spi_mem_ctrl.sv
// tb_spi_mem_ctrl: table-driven frames with a scoreboard of expected memory/response pulses
module tb_spi_mem_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  spi_mem_ctrl_if #(.ADDR_SIZE(8)) if0();
  spi_mem_ctrl_if #(.ADDR_SIZE(8)) if1();
  spi_mem_ctrl #(.ADDR_SIZE(8), .AUTO_INC(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  spi_mem_ctrl #(.ADDR_SIZE(8), .AUTO_INC(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  // memory returns addr^D2 only in the cycle after mem_re, junk otherwise
  always @(posedge clk) begin
    if0.mem_rdata <= if0.mem_re ? if0.mem_addr ^ 8'hD2 : 8'hEE;
    if1.mem_rdata <= if1.mem_re ? if1.mem_addr ^ 8'hD2 : 8'hEE;
  end
  typedef struct {
    int         dut;
    int         kind;
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } ev_t;
  typedef struct {
    logic [9:0] rx;
    logic       we;
    logic       re;
    logic       er;
    logic [7:0] addr;
    logic [7:0] data;
  } vec_t;
  ev_t   q[$];
  vec_t  tbl[14];
  string kn[4] = '{"mem_we", "mem_re", "tx_valid", "cmd_err"};
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask
  task automatic match(input int d, input int k, input logic [7:0] a, input logic [7:0] dt);
    int idx;
    idx = -1;
    for (int i = 0; i < q.size(); i++)
      if (idx < 0 && q[i].dut == d && q[i].kind == k) idx = i;
    n_vec++;
    if (idx < 0) begin
      n_bad++;
      $display("FAIL %s dut%0d cyc %0d: unexpected pulse addr %h data %h, required no pulse", kn[k], d, cyc, a, dt);
    end else begin
      if (q[idx].cyc != cyc || q[idx].addr !== a || q[idx].data !== dt) begin
        n_bad++;
        $display("FAIL %s dut%0d: got cyc %0d addr %h data %h, required cyc %0d addr %h data %h",
                 kn[k], d, cyc, a, dt, q[idx].cyc, q[idx].addr, q[idx].data);
      end
      q.delete(idx);
    end
  endtask
  task automatic mon(input int d, input logic we, input logic re, input logic tv, input logic er,
                     input logic [7:0] addr, input logic [7:0] wd, input logic [7:0] td);
    if (we) match(d, 0, addr, wd);
    if (re) match(d, 1, addr, 8'h00);
    if (tv) match(d, 2, 8'h00, td);
    if (er) match(d, 3, 8'h00, 8'h00);
    n_vec++;
    if ((we && re) || (!we && !re && addr != 8'h00)) begin
      n_bad++;
      $display("FAIL mem_excl dut%0d cyc %0d: we=%b re=%b addr=%h, required exclusive enables and addr 00 when idle",
               d, cyc, we, re, addr);
    end
  endtask
  always @(negedge clk) begin
    mon(0, if0.mem_we, if0.mem_re, if0.tx_valid, if0.cmd_err, if0.mem_addr, if0.mem_wdata, if0.tx_data);
    mon(1, if1.mem_we, if1.mem_re, if1.tx_valid, if1.cmd_err, if1.mem_addr, if1.mem_wdata, if1.tx_data);
  end
  task automatic send(input int d, input logic [9:0] rx, input logic we, input logic re, input logic er,
                      input logic [7:0] a, input logic [7:0] dt);
    @(negedge clk);
    if (d == 0) begin
      if0.rx_data  = rx;
      if0.rx_valid = 1'b1;
    end else begin
      if1.rx_data  = rx;
      if1.rx_valid = 1'b1;
    end
    if (we) q.push_back('{d, 0, a, dt, cyc + 1});
    if (re) begin
      q.push_back('{d, 1, a, 8'h00, cyc + 1});
      q.push_back('{d, 2, 8'h00, dt, cyc + 3});
    end
    if (er) q.push_back('{d, 3, 8'h00, 8'h00, cyc + 1});
    @(negedge clk);
    if0.rx_valid = 1'b0;
    if1.rx_valid = 1'b0;
  endtask
  task automatic chk_zero(input int d, input string nm);
    if (d == 0)
      chk(nm, {if0.tx_data, if0.tx_valid, if0.mem_addr, if0.mem_wdata, if0.mem_we, if0.mem_re, if0.busy, if0.cmd_err}, 64'd0);
    else
      chk(nm, {if1.tx_data, if1.tx_valid, if1.mem_addr, if1.mem_wdata, if1.mem_we, if1.mem_re, if1.busy, if1.cmd_err}, 64'd0);
  endtask
  initial begin
    tbl[0]  = '{10'h300, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00};
    tbl[1]  = '{10'h100, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00};
    tbl[2]  = '{10'h0A5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[3]  = '{10'h13C, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C};
    tbl[4]  = '{10'h2A5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[5]  = '{10'h300, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h77};
    tbl[6]  = '{10'h300, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00};
    tbl[7]  = '{10'h1C3, 1'b1, 1'b0, 1'b0, 8'hA5, 8'hC3};
    tbl[8]  = '{10'h210, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[9]  = '{10'h3FF, 1'b0, 1'b1, 1'b0, 8'h10, 8'hC2};
    tbl[10] = '{10'h200, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[11] = '{10'h300, 1'b0, 1'b1, 1'b0, 8'h00, 8'hD2};
    tbl[12] = '{10'h0FF, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[13] = '{10'h155, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h55};
    if0.rx_data = '0; if0.rx_valid = 1'b0;
    if1.rx_data = '0; if1.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero(0, "reset_outputs_dut0");
    chk_zero(1, "reset_outputs_dut1");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    foreach (tbl[i]) begin
      send(0, tbl[i].rx, tbl[i].we, tbl[i].re, tbl[i].er, tbl[i].addr, tbl[i].data);
      repeat (4) @(negedge clk);
    end
    // frame landing in RD_WAIT is dropped; read still answers at N+3
    send(0, 10'h2A5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    send(0, 10'h300, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h77);
    send(0, 10'h0AA, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    repeat (4) @(negedge clk);
    send(0, 10'h111, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h11);
    repeat (4) @(negedge clk);
    send(1, 10'h2FF, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    send(1, 10'h300, 1'b0, 1'b1, 1'b0, 8'hFF, 8'h2D);
    repeat (4) @(negedge clk);
    send(1, 10'h300, 1'b0, 1'b1, 1'b0, 8'h00, 8'hD2);
    repeat (4) @(negedge clk);
    send(1, 10'h300, 1'b0, 1'b1, 1'b0, 8'h01, 8'hD3);
    repeat (4) @(negedge clk);
    send(1, 10'h0FE, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    send(1, 10'h111, 1'b1, 1'b0, 1'b0, 8'hFE, 8'h11);
    repeat (2) @(negedge clk);
    send(1, 10'h122, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h22);
    repeat (2) @(negedge clk);
    send(1, 10'h133, 1'b1, 1'b0, 1'b0, 8'h00, 8'h33);
    repeat (4) @(negedge clk);
    send(0, 10'h2A5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    send(0, 10'h300, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h77);
    @(posedge clk);
    #2;
    chk("busy_rd_wait", {63'd0, if0.busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk_zero(0, "async_reset_outputs");
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].dut == 0 && q[i].kind == 2) q.delete(i);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    send(0, 10'h300, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    repeat (4) @(negedge clk);
    foreach (q[i]) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s dut%0d: no pulse seen, required one at cyc %0d addr %h data %h",
               kn[q[i].kind], q[i].dut, q[i].cyc, q[i].addr, q[i].data);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
